ef_i2s_tdm_rx: RTL and testbench
================================

# ef_i2s_tdm_rx

Parametrised multi-slot audio serial receiver and bus master: generates SCK/WS, deserialises SDI in I2S (Philips), left-justified or TDM (DSP short-frame) format, and presents one sample per enabled slot on a valid/ready stream. It replaces the fixed two-channel receive front end and feeds the existing sample FIFO and VAD logic. Slot count, slot width, sample size and per-slot enables are configurable.

## Interface
- SLOTS, 2, slots per frame (2..8; even in I2S/LJ modes)
- SLOT_W, 32, bits per slot (16..32)
- PRE_W, 8, prescaler width
- SLOT_IW, $clog2(SLOTS), slot index width (derived)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  run enable; low returns the serial engine to IDLE
- sck_prescaler  in  PRE_W  SCK half-period minus one, in clk cycles
- frame_mode  in  2  00 I2S, 01 left-justified, 10 TDM; 11 reserved, treated as TDM
- sample_size  in  6  valid MSBs per slot; 0 or >SLOT_W means SLOT_W
- sign_extend  in  1  sign-extend right-aligned sample to 32 bits
- slot_mask  in  SLOTS  bit i set: emit slot i
- sck  out  1  serial clock
- ws  out  1  word select / frame sync
- sdi  in  1  serial data, already synchronous to clk
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accept
- m_data  out  32  right-aligned sample
- m_slot  out  SLOT_IW  slot index of m_data
- overrun  out  1  sticky: word dropped while m_valid=1 and m_ready=0
- overrun_clr  in  1  clears overrun

## Operation
- FSM states: IDLE and RUN. IDLE→RUN on en=1. RUN→IDLE on en=0, effective the next cycle. Entering RUN loads cnt=sck_prescaler, bit_ctr=0, sck=0, ws=ws_of(0), and clears the primed flag.
- tick = RUN & cnt==0. On tick, cnt reloads and sck toggles; otherwise cnt decrements.
- Rise tick (sck 0→1): sr <= {sr, sdi}.
- Fall tick (sck 1→0): bit_ctr advances modulo SLOTS*SLOT_W and ws <= ws_of(next bit_ctr).
- ws_of(b):
  - I2S/LJ: 1 when b/SLOT_W >= SLOTS/2.
  - TDM: 1 only when b==0.
- Data bit index d = bit_ctr − delay (mod frame). delay=1 in I2S, 0 otherwise.
- On the rise tick that captures d%SLOT_W == SLOT_W−1, the slot s=d/SLOT_W is complete.
  - I2S: the first completion after entering RUN is discarded (primed flag).
  - Word w = top sample_size bits of the slot, right-aligned. If sign_extend=1, bits above are copied from the slot MSB; otherwise they are 0.
  - If slot_mask[s]=1: when the output register is empty or being accepted, load m_data=w, m_slot=s, m_valid=1. Otherwise drop the word and set overrun.
- m_valid clears on m_valid&m_ready unless a new word loads the same cycle.
- overrun_clr and a simultaneous set: set wins.
- frame_mode, sample_size and SLOTS-dependent config must be static while en=1; changes take effect on the next IDLE→RUN.
- slot_mask may change at any time and is sampled at word completion.
- en=0 does not touch m_valid, m_data, m_slot or overrun; a pending word stays until accepted.

## Timing
- Reset values: sck=0, ws=0, m_valid=0, m_data=0, m_slot=0, overrun=0; internal cnt=0, bit_ctr=0, state IDLE.
- SCK period is 2*(sck_prescaler+1) clk. The first rise occurs sck_prescaler+1 cycles after RUN entry.
- ws changes on the same clk edge as the sck falling edge.
- m_valid rises on the clk edge of the capturing rise tick; latency 0 cycles after the last bit is sampled.
- Reset mid-frame: everything returns to reset values immediately and the partial word is lost.
- The fastest word rate (SLOT_W=16, prescaler=0) is one word per 32 clk. The handshake has no bubble: accept-and-load occurs in the same cycle.

## Structure
- Package ef_i2s_pkg holds mode constants I2S_MODE_I2S, I2S_MODE_LJ, I2S_MODE_TDM and the frame_mode_t typedef.
- One natural sub-module, ef_i2s_sck_gen: prescaler, sck, and rise/fall tick strobes. Bit counter, ws, shifter and stream register stay in the top level.

## Test plan
- SLOTS=2, SLOT_W=32, prescaler=1, I2S, sample_size=24, sign_extend=1. Drive left 0xA5A50000, right 0x12345678 → (0xFFA5A500, slot 0), then (0x00123456, slot 1). The first post-enable completion is discarded.
- Same frames in LJ mode with sign_extend=0, sample_size=32 → (0xA5A50000, 0), (0x12345678, 1). ws toggles exactly every 64 sck edges.
- SLOTS=8, SLOT_W=16, TDM, prescaler=0, slot_mask=0x05, slot i = 0x1000+i → only (0x1000,0) and (0x1002,2). ws high for exactly 2 clk per 256-clk frame.
- m_ready=0 across two enabled words → first word held, second dropped, overrun=1. overrun_clr pulse → 0. m_ready=1 → held word delivered once.
- Assert rst mid-slot with m_valid=1 → all outputs return to reset values the same cycle. After release with en=1, the next frame decodes correctly.
- Drop en mid-frame with a pending word → sck/ws return to 0, word retained until m_ready. Re-enabling restarts at bit 0.

Source files
------------

// File: rtl/ef_i2s_pkg.sv
// Shared frame-format constants and state encoding for the multi-slot audio serial receiver.
package ef_i2s_pkg;

   typedef logic [1:0] frame_mode_t;

   localparam frame_mode_t I2S_MODE_I2S = 2'b00;
   localparam frame_mode_t I2S_MODE_LJ  = 2'b01;
   localparam frame_mode_t I2S_MODE_TDM = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } rx_state_t;

endpackage

// File: rtl/ef_i2s_sck_gen.sv
// Serial clock generator: prescaled SCK with one-cycle strobes on the cycle before each rise/fall.
module ef_i2s_sck_gen
   import ef_i2s_pkg::*;
#(
   parameter int PRE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             run,
   input  logic             stop,
   input  logic [PRE_W-1:0] prescaler,
   output logic             sck,
   output logic             rise_tick,
   output logic             fall_tick
);

   logic [PRE_W-1:0] cnt_r;
   logic             sck_r;
   logic             tick_s;

   assign tick_s    = run && (cnt_r == {PRE_W{1'b0}});
   assign rise_tick = tick_s && !sck_r;
   assign fall_tick = tick_s && sck_r;
   assign sck       = sck_r;

   // Half-period down-counter and SCK toggle register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {PRE_W{1'b0}};
         sck_r <= 1'b0;
      end else if (load) begin
         cnt_r <= prescaler;
         sck_r <= 1'b0;
      end else if (stop) begin
         cnt_r <= {PRE_W{1'b0}};
         sck_r <= 1'b0;
      end else if (tick_s) begin
         cnt_r <= prescaler;
         sck_r <= ~sck_r;
      end else if (run) begin
         cnt_r <= cnt_r - {{(PRE_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/ef_i2s_tdm_rx.sv
// Multi-slot I2S / left-justified / TDM receiver and bus master with a valid/ready sample output.
module ef_i2s_tdm_rx
   import ef_i2s_pkg::*;
#(
   parameter int SLOTS   = 2,
   parameter int SLOT_W  = 32,
   parameter int PRE_W   = 8,
   parameter int SLOT_IW = $clog2(SLOTS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PRE_W-1:0]   sck_prescaler,
   input  logic [1:0]         frame_mode,
   input  logic [5:0]         sample_size,
   input  logic               sign_extend,
   input  logic [SLOTS-1:0]   slot_mask,
   output logic               sck,
   output logic               ws,
   input  logic               sdi,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [31:0]        m_data,
   output logic [SLOT_IW-1:0] m_slot,
   output logic               overrun,
   input  logic               overrun_clr
);

   localparam int            FRAME     = SLOTS * SLOT_W;
   localparam int            FW        = $clog2(FRAME);
   localparam logic [FW-1:0] LAST_BIT  = FW'(FRAME - 1);
   localparam logic [FW-1:0] HALF_BIT  = FW'(FRAME / 2);
   localparam logic [FW-1:0] SLOT_W_F  = FW'(SLOT_W);
   localparam logic [FW-1:0] SLOT_LAST = FW'(SLOT_W - 1);
   localparam logic [FW-1:0] ONE_F     = FW'(1);
   localparam logic [5:0]    SLOT_W6   = 6'(SLOT_W);

   rx_state_t           state_r, state_nx_s;
   logic                load_s, run_s, stop_s, rise_s, fall_s;
   logic [FW-1:0]       bit_ctr_r, bit_nx_s, d_s;
   logic                ws_r, primed_r;
   frame_mode_t         mode_r;
   logic [5:0]          ss_r, ss_eff_s;
   logic [SLOT_W-2:0]   sr_r;
   logic [SLOT_W-1:0]   slot_word_s;
   logic [31:0]         slot32_s, word_s;
   logic [SLOT_IW-1:0]  slot_i_s;
   logic                complete_s, emit_s, load_out_s, drop_s;
   logic                m_valid_r, overrun_r;
   logic [31:0]         m_data_r;
   logic [SLOT_IW-1:0]  m_slot_r;

   function automatic logic ws_of(input frame_mode_t mode, input logic [FW-1:0] b);
      logic w;
      case (mode)
         I2S_MODE_I2S, I2S_MODE_LJ: w = (b >= HALF_BIT);
         default:                   w = (b == {FW{1'b0}});
      endcase
      return w;
   endfunction

   assign load_s = (state_r == ST_IDLE) && en;
   assign run_s  = (state_r == ST_RUN) && en;
   assign stop_s = (state_r == ST_RUN) && !en;

   ef_i2s_sck_gen #(.PRE_W(PRE_W)) u_sck_gen (
      .clk       (clk),
      .rst       (rst),
      .load      (load_s),
      .run       (run_s),
      .stop      (stop_s),
      .prescaler (sck_prescaler),
      .sck       (sck),
      .rise_tick (rise_s),
      .fall_tick (fall_s)
   );

   // Run-state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nx_s;
   end

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: if (en) state_nx_s = ST_RUN;  else state_nx_s = ST_IDLE;
         ST_RUN:  if (en) state_nx_s = ST_RUN;  else state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Data-bit position (I2S lags ws by one bit), slot completion and word formatting.
   always_comb begin
      bit_nx_s = bit_ctr_r;
      d_s      = bit_ctr_r;
      ss_eff_s = sample_size;
      if (bit_ctr_r == LAST_BIT) bit_nx_s = {FW{1'b0}};
      else                       bit_nx_s = bit_ctr_r + ONE_F;
      if (mode_r != I2S_MODE_I2S)          d_s = bit_ctr_r;
      else if (bit_ctr_r == {FW{1'b0}})    d_s = LAST_BIT;
      else                                 d_s = bit_ctr_r - ONE_F;
      if ((sample_size == 6'd0) || (sample_size > SLOT_W6)) ss_eff_s = SLOT_W6;
      else                                                  ss_eff_s = sample_size;
      slot_i_s    = SLOT_IW'(d_s / SLOT_W_F);
      complete_s  = rise_s && ((d_s % SLOT_W_F) == SLOT_LAST);
      slot_word_s = {sr_r, sdi};
      slot32_s    = 32'(slot_word_s) >> (SLOT_W6 - ss_r);
      if (sign_extend && slot_word_s[SLOT_W-1]) word_s = slot32_s | (32'hFFFF_FFFF << ss_r);
      else                                      word_s = slot32_s;
      emit_s     = complete_s && !((mode_r == I2S_MODE_I2S) && !primed_r) && slot_mask[slot_i_s];
      load_out_s = emit_s && (!m_valid_r || m_ready);
      drop_s     = emit_s && m_valid_r && !m_ready;
   end

   // Bit counter, word select, shifter and per-run configuration capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_ctr_r <= {FW{1'b0}};
         ws_r      <= 1'b0;
         sr_r      <= {(SLOT_W-1){1'b0}};
         primed_r  <= 1'b0;
         mode_r    <= I2S_MODE_I2S;
         ss_r      <= 6'd0;
      end else if (load_s) begin
         bit_ctr_r <= {FW{1'b0}};
         ws_r      <= ws_of(frame_mode, {FW{1'b0}});
         primed_r  <= 1'b0;
         mode_r    <= frame_mode;
         ss_r      <= ss_eff_s;
      end else if (stop_s) begin
         bit_ctr_r <= {FW{1'b0}};
         ws_r      <= 1'b0;
      end else begin
         if (rise_s)     sr_r     <= slot_word_s[SLOT_W-2:0];
         if (complete_s) primed_r <= 1'b1;
         if (fall_s) begin
            bit_ctr_r <= bit_nx_s;
            ws_r      <= ws_of(mode_r, bit_nx_s);
         end
      end
   end

   // Output stream register and sticky overrun flag; a new set beats a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid_r <= 1'b0;
         m_data_r  <= 32'd0;
         m_slot_r  <= {SLOT_IW{1'b0}};
         overrun_r <= 1'b0;
      end else begin
         if (load_out_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= word_s;
            m_slot_r  <= slot_i_s;
         end else if (m_ready) begin
            m_valid_r <= 1'b0;
         end
         if (drop_s)           overrun_r <= 1'b1;
         else if (overrun_clr) overrun_r <= 1'b0;
      end
   end

   assign ws      = ws_r;
   assign m_valid = m_valid_r;
   assign m_data  = m_data_r;
   assign m_slot  = m_slot_r;
   assign overrun = overrun_r;

endmodule

// File: tb/tb_ef_i2s_tdm_rx.sv
// Directed bench: a 2x32 instance exercised in I2S/LJ and a 8x16 instance in TDM.
module tb_ef_i2s_tdm_rx;

   localparam logic [31:0] L_WORD = 32'hA5A5_0000;
   localparam logic [31:0] R_WORD = 32'h1234_5678;

   logic        clk = 1'b0;
   logic        rst;

   logic        en_a, sign_extend_a, sdi_a, m_ready_a, overrun_clr_a;
   logic        sck_a, ws_a, m_valid_a, overrun_a;
   logic [7:0]  sck_prescaler_a;
   logic [1:0]  frame_mode_a;
   logic [5:0]  sample_size_a;
   logic [1:0]  slot_mask_a;
   logic [31:0] m_data_a;
   logic [0:0]  m_slot_a;

   logic        en_b, sign_extend_b, sdi_b, m_ready_b, overrun_clr_b;
   logic        sck_b, ws_b, m_valid_b, overrun_b;
   logic [7:0]  sck_prescaler_b;
   logic [1:0]  frame_mode_b;
   logic [5:0]  sample_size_b;
   logic [7:0]  slot_mask_b;
   logic [31:0] m_data_b;
   logic [2:0]  m_slot_b;

   int total  = 0;
   int passed = 0;
   int dl_a   = 0;

   always #5 clk = ~clk;

   ef_i2s_tdm_rx #(.SLOTS(2), .SLOT_W(32), .PRE_W(8)) u_dut_a (
      .clk(clk), .rst(rst), .en(en_a), .sck_prescaler(sck_prescaler_a),
      .frame_mode(frame_mode_a), .sample_size(sample_size_a), .sign_extend(sign_extend_a),
      .slot_mask(slot_mask_a), .sck(sck_a), .ws(ws_a), .sdi(sdi_a),
      .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a), .m_slot(m_slot_a),
      .overrun(overrun_a), .overrun_clr(overrun_clr_a)
   );

   ef_i2s_tdm_rx #(.SLOTS(8), .SLOT_W(16), .PRE_W(8)) u_dut_b (
      .clk(clk), .rst(rst), .en(en_b), .sck_prescaler(sck_prescaler_b),
      .frame_mode(frame_mode_b), .sample_size(sample_size_b), .sign_extend(sign_extend_b),
      .slot_mask(slot_mask_b), .sck(sck_b), .ws(ws_b), .sdi(sdi_b),
      .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_slot(m_slot_b),
      .overrun(overrun_b), .overrun_clr(overrun_clr_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   // Waits for the next SCK rise of the selected instance, bounded by a cycle budget.
   task automatic wait_rise(input bit use_b);
      logic p;
      int   n;
      p = use_b ? sck_b : sck_a;
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         n = n + 1;
         if (!p && (use_b ? sck_b : sck_a)) break;
         p = use_b ? sck_b : sck_a;
         if (n > 40) begin
            total = total + 1;
            $error("FAIL sck_timeout: observed no rising sck in %0d clk, expected one", n);
            break;
         end
      end
   endtask

   task automatic step_a(input int b);
      int          d;
      logic [31:0] w;
      d = (b - dl_a + 64) % 64;
      w = (d < 32) ? L_WORD : R_WORD;
      sdi_a = w[31 - (d % 32)];
      wait_rise(1'b0);
   endtask

   task automatic run_a(input int from, input int to);
      for (int b = from; b <= to; b++) step_a(b);
   endtask

   task automatic step_b(input int b);
      int          d;
      logic [15:0] w;
      d = b % 128;
      w = 16'h1000 + 16'(d / 16);
      sdi_b = w[15 - (d % 16)];
      wait_rise(1'b1);
   endtask

   task automatic run_b(input int from, input int to);
      for (int b = from; b <= to; b++) step_b(b);
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_sck"},     32'(sck_a),     32'd0);
      chk({tag, "_ws"},      32'(ws_a),      32'd0);
      chk({tag, "_valid"},   32'(m_valid_a), 32'd0);
      chk({tag, "_data"},    m_data_a,       32'd0);
      chk({tag, "_slot"},    32'(m_slot_a),  32'd0);
      chk({tag, "_overrun"}, 32'(overrun_a), 32'd0);
   endtask

   initial begin
      int nv;
      int hi;
      rst = 1'b1;
      en_a = 1'b0; sck_prescaler_a = 8'd1; frame_mode_a = 2'b00; sample_size_a = 6'd24;
      sign_extend_a = 1'b1; sdi_a = 1'b0; m_ready_a = 1'b1; overrun_clr_a = 1'b0; slot_mask_a = 2'b11;
      en_b = 1'b0; sck_prescaler_b = 8'd0; frame_mode_b = 2'b10; sample_size_b = 6'd0;
      sign_extend_b = 1'b0; sdi_b = 1'b0; m_ready_b = 1'b1; overrun_clr_b = 1'b0; slot_mask_b = 8'h05;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_a("por");
      chk("por_valid_b", 32'(m_valid_b), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // I2S, 24-bit signed samples; the first completion after enable is garbage.
      dl_a = 1; en_a = 1'b1;
      step_a(0);
      chk("i2s_prime_drop", 32'(m_valid_a), 32'd0);
      run_a(1, 32);
      chk("i2s_l_valid", 32'(m_valid_a), 32'd1);
      chk("i2s_l_data",  m_data_a,       32'hFFA5_A500);
      chk("i2s_l_slot",  32'(m_slot_a),  32'd0);
      chk("i2s_l_ws",    32'(ws_a),      32'd1);
      run_a(33, 64);
      chk("i2s_r_data",  m_data_a,       32'h0012_3456);
      chk("i2s_r_slot",  32'(m_slot_a),  32'd1);
      chk("i2s_r_ws",    32'(ws_a),      32'd0);
      en_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("i2s_off_sck", 32'(sck_a), 32'd0);

      // Left-justified, full 32-bit unsigned samples.
      frame_mode_a = 2'b01; sample_size_a = 6'd32; sign_extend_a = 1'b0; dl_a = 0; en_a = 1'b1;
      run_a(0, 31);
      chk("lj_l_data", m_data_a,      32'hA5A5_0000);
      chk("lj_l_slot", 32'(m_slot_a), 32'd0);
      chk("lj_ws31",   32'(ws_a),     32'd0);
      step_a(32);
      chk("lj_ws32",   32'(ws_a),     32'd1);
      run_a(33, 63);
      chk("lj_r_data", m_data_a,      32'h1234_5678);
      chk("lj_r_slot", 32'(m_slot_a), 32'd1);
      chk("lj_ws63",   32'(ws_a),     32'd1);
      step_a(64);
      chk("lj_ws64",   32'(ws_a),     32'd0);

      // Back-pressure: hold the left word, drop the right one.
      m_ready_a = 1'b0;
      run_a(65, 95);
      chk("ovr_held_valid", 32'(m_valid_a), 32'd1);
      run_a(96, 127);
      chk("ovr_set",        32'(overrun_a), 32'd1);
      chk("ovr_held_data",  m_data_a,       32'hA5A5_0000);
      chk("ovr_held_slot",  32'(m_slot_a),  32'd0);

      // Drop en in the right half with a pending word.
      en_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("off_sck",       32'(sck_a),     32'd0);
      chk("off_ws",        32'(ws_a),      32'd0);
      chk("off_valid",     32'(m_valid_a), 32'd1);
      overrun_clr_a = 1'b1;
      @(posedge clk);
      #1;
      overrun_clr_a = 1'b0;
      chk("ovr_clr",       32'(overrun_a), 32'd0);
      chk("off_data",      m_data_a,       32'hA5A5_0000);
      m_ready_a = 1'b1;
      @(posedge clk);
      #1;
      chk("deliver_once",  32'(m_valid_a), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("deliver_no_repeat", 32'(m_valid_a), 32'd0);

      // Re-enable restarts at bit 0, then reset mid-slot with a pending word.
      m_ready_a = 1'b0; en_a = 1'b1;
      run_a(0, 31);
      chk("restart_valid", 32'(m_valid_a), 32'd1);
      chk("restart_data",  m_data_a,       32'hA5A5_0000);
      run_a(32, 40);
      rst = 1'b1;
      #1;
      chk_reset_a("midrst");
      m_ready_a = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_a(0, 31);
      chk("postrst_l_data", m_data_a,      32'hA5A5_0000);
      chk("postrst_l_slot", 32'(m_slot_a), 32'd0);
      run_a(32, 63);
      chk("postrst_r_data", m_data_a,      32'h1234_5678);
      chk("postrst_r_slot", 32'(m_slot_a), 32'd1);
      en_a = 1'b0;

      // TDM, 8 x 16-bit slots, only slots 0 and 2 enabled.
      en_b = 1'b1;
      step_b(0);
      chk("tdm_ws_b0", 32'(ws_b), 32'd1);
      step_b(1);
      chk("tdm_ws_b1", 32'(ws_b), 32'd0);
      run_b(2, 15);
      chk("tdm_s0_valid", 32'(m_valid_b), 32'd1);
      chk("tdm_s0_data",  m_data_b,       32'h0000_1000);
      chk("tdm_s0_slot",  32'(m_slot_b),  32'd0);
      run_b(16, 31);
      chk("tdm_s1_masked", 32'(m_valid_b), 32'd0);
      run_b(32, 47);
      chk("tdm_s2_valid", 32'(m_valid_b), 32'd1);
      chk("tdm_s2_data",  m_data_b,       32'h0000_1002);
      chk("tdm_s2_slot",  32'(m_slot_b),  32'd2);
      nv = 0;
      for (int b = 48; b <= 127; b++) begin
         step_b(b);
         nv = nv + int'(m_valid_b);
      end
      chk("tdm_masked_rest", 32'(nv), 32'd0);
      hi = 0;
      repeat (256) begin
         @(negedge clk);
         hi = hi + int'(ws_b);
      end
      chk("tdm_ws_width", 32'(hi), 32'd2);
      en_b = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
